next_pc_unit: RTL and testbench

- Parametrised successor to the decode-stage next-PC select. Owns the fetch PC register and arbitrates NUM_SRC prioritised redirect channels, the BTB prediction and sequential PC+INST_BYTES.
- Latches a redirect that arrives while fetch is stalled and applies it when fetch resumes.
- Drives per-stage squash and a saturating redirect counter.
- Sits between the pipeline redirect sources and the I-cache request port.

---
 rtl/next_pc_pkg.sv | 20 ++
 rtl/redirect_prio_enc.sv | 20 ++
 rtl/next_pc_unit.sv | 94 +++++++++
 tb/tb_next_pc_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_pkg.sv
// Shared types and constants for the fetch next-PC selection logic.
package next_pc_pkg;

    localparam int unsigned NUM_SRC_DEFAULT = 4;
    localparam int unsigned SRC_IDX_W       = $clog2(NUM_SRC_DEFAULT);

    typedef logic [SRC_IDX_W-1:0] src_idx_t;

    // Higher index = older pipeline stage = higher redirect priority
    localparam src_idx_t SRC_DECODE  = src_idx_t'(0);
    localparam src_idx_t SRC_EXEC    = src_idx_t'(1);
    localparam src_idx_t SRC_MEM_BR  = src_idx_t'(2);
    localparam src_idx_t SRC_MEM_IND = src_idx_t'(3);

    typedef enum logic {
        RUN,
        HOLD
    } pc_state_t;

endpackage

// File: rtl/redirect_prio_enc.sv
// Priority encoder selecting the highest-index asserted redirect channel.
module redirect_prio_enc #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] valid,
    output logic               any_valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        any_valid = |valid;
        idx       = '0;
        // Ascending scan so the last (highest) asserted index wins
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (valid[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with prioritised redirect arbitration, stall-time
// redirect capture, per-stage squash and a saturating redirect counter.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int unsigned       WIDTH      = 16,
    parameter int unsigned       NUM_SRC    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned       INST_BYTES = 2,
    parameter int unsigned       CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fetch_ready,
    input  logic [NUM_SRC-1:0]                redirect_valid,
    input  logic [NUM_SRC-1:0][WIDTH-1:0]     redirect_target,
    input  logic                              pred_valid,
    input  logic [WIDTH-1:0]                  pred_target,
    output logic [WIDTH-1:0]                  pc,
    output logic [NUM_SRC-1:0]                squash,
    output logic                              pending_valid,
    output logic [CNT_WIDTH-1:0]              redirect_count
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    pc_state_t        state, state_next;
    logic [IDX_W-1:0] pending_src, fresh_src, eff_src;
    logic [WIDTH-1:0] pending_target, eff_target, next_pc;
    logic             fresh_any, eff_valid;

    redirect_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio (
        .valid     (redirect_valid),
        .any_valid (fresh_any),
        .idx       (fresh_src)
    );

    assign pending_valid = (state == HOLD);

    // Pending entry only beats a fresh redirect from a strictly older stage
    always_comb begin
        eff_valid  = fresh_any | pending_valid;
        eff_src    = fresh_src;
        eff_target = redirect_target[fresh_src];
        if (pending_valid && (!fresh_any || (pending_src > fresh_src))) begin
            eff_src    = pending_src;
            eff_target = pending_target;
        end
    end

    always_comb begin
        squash = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (eff_valid && (32'(eff_src) > j)) squash[j] = 1'b1;
        end
    end

    always_comb begin
        if (eff_valid)       next_pc = eff_target;
        else if (pred_valid) next_pc = pred_target;
        else                 next_pc = pc + WIDTH'(INST_BYTES);
    end

    always_comb begin
        state_next = state;
        if (fetch_ready)    state_next = RUN;
        else if (eff_valid) state_next = HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            pending_src    <= '0;
            pending_target <= '0;
            redirect_count <= '0;
        end else if (fetch_ready) begin
            pc <= next_pc;
            if (eff_valid && (redirect_count != '1))
                redirect_count <= redirect_count + 1'b1;
        end else if (eff_valid) begin
            pending_src    <= eff_src;
            pending_target <= eff_target;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: table-driven scenarios, expected state queued per cycle.
module tb_next_pc_unit;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  fetch_ready;
    logic [3:0]            redirect_valid;
    logic [3:0][15:0]      redirect_target;
    logic                  pred_valid;
    logic [15:0]           pred_target;
    logic [15:0]           pc;
    logic [3:0]            squash;
    logic                  pending_valid;
    logic [3:0]            redirect_count;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    typedef struct {
        string       name;
        logic        rs;
        logic        rdy;
        logic [3:0]  rv;
        logic [15:0] tgt;
        logic        pv;
        logic [15:0] pt;
        logic        chk_sq;
        logic [3:0]  sq;
        logic [15:0] epc;
        logic        epend;
        logic [3:0]  ecnt;
    } row_t;

    row_t exp_q[$];

    next_pc_unit #(
        .WIDTH      (16),
        .NUM_SRC    (4),
        .RESET_PC   (16'h0000),
        .INST_BYTES (2),
        .CNT_WIDTH  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pred_valid      (pred_valid),
        .pred_target     (pred_target),
        .pc              (pc),
        .squash          (squash),
        .pending_valid   (pending_valid),
        .redirect_count  (redirect_count)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input string n, input logic rs, input logic rdy,
                                input logic [3:0] rv, input logic [15:0] tgt,
                                input logic pv, input logic [15:0] pt,
                                input logic chk, input logic [3:0] sq,
                                input logic [15:0] epc, input logic epend,
                                input logic [3:0] ecnt);
        row_t r;
        r.name = n; r.rs = rs; r.rdy = rdy; r.rv = rv; r.tgt = tgt;
        r.pv = pv; r.pt = pt; r.chk_sq = chk; r.sq = sq;
        r.epc = epc; r.epend = epend; r.ecnt = ecnt;
        return r;
    endfunction

    // Idle channels carry distinct junk targets so a wrong mux select is visible
    task automatic apply(input row_t r);
        rst            = r.rs;
        fetch_ready    = r.rdy;
        redirect_valid = r.rv;
        pred_valid     = r.pv;
        pred_target    = r.pt;
        for (int i = 0; i < 4; i++)
            redirect_target[i] = r.rv[i] ? r.tgt : (16'hDEA0 + 16'(i));
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("reset", 1, 0, 4'b0000, 16'h0, 0, 16'h0, 0, 4'b0000, 16'h0000, 0, 4'h0));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    task automatic test_sequential();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("seq1", 0, 1, 4'b0000, 16'h0, 0, 16'h0, 1, 4'b0000, 16'h0002, 0, 4'h0));
        rows.push_back(mk("seq2", 0, 1, 4'b0000, 16'h0, 0, 16'h0, 1, 4'b0000, 16'h0004, 0, 4'h0));
        rows.push_back(mk("seq3", 0, 1, 4'b0000, 16'h0, 0, 16'h0, 1, 4'b0000, 16'h0006, 0, 4'h0));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    task automatic test_pred_vs_redirect();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("pred_only",     0, 1, 4'b0000, 16'h0000, 1, 16'h0010, 1, 4'b0000, 16'h0010, 0, 4'h0));
        rows.push_back(mk("pred_vs_redir", 0, 1, 4'b0010, 16'h0080, 1, 16'h0040, 1, 4'b0001, 16'h0080, 0, 4'h1));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("stall_r1",   0, 0, 4'b0010, 16'h0100, 0, 16'h0000, 1, 4'b0001, 16'h0080, 1, 4'h1));
        rows.push_back(mk("stall_r3",   0, 0, 4'b1000, 16'h0200, 0, 16'h0000, 1, 4'b0111, 16'h0080, 1, 4'h1));
        rows.push_back(mk("stall_r0",   0, 0, 4'b0001, 16'h0300, 0, 16'h0000, 1, 4'b0111, 16'h0080, 1, 4'h1));
        rows.push_back(mk("stall_pred", 0, 0, 4'b0000, 16'h0000, 1, 16'h0999, 1, 4'b0111, 16'h0080, 1, 4'h1));
        rows.push_back(mk("release",    0, 1, 4'b0000, 16'h0000, 1, 16'h0999, 1, 4'b0111, 16'h0200, 0, 4'h2));
        rows.push_back(mk("after_rel",  0, 1, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0000, 16'h0202, 0, 4'h2));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    task automatic test_tie_and_wrap();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("tie_pend",       0, 0, 4'b0100, 16'h0500, 0, 16'h0000, 1, 4'b0011, 16'h0202, 1, 4'h2));
        rows.push_back(mk("tie_fresh",      0, 1, 4'b0100, 16'h0600, 0, 16'h0000, 1, 4'b0011, 16'h0600, 0, 4'h3));
        rows.push_back(mk("hold_src3",      0, 0, 4'b1000, 16'h0A00, 0, 16'h0000, 1, 4'b0111, 16'h0600, 1, 4'h3));
        rows.push_back(mk("pend_beats_low", 0, 1, 4'b0010, 16'h0B00, 0, 16'h0000, 1, 4'b0111, 16'h0A00, 0, 4'h4));
        rows.push_back(mk("to_fffe",        0, 1, 4'b0000, 16'h0000, 1, 16'hFFFE, 1, 4'b0000, 16'hFFFE, 0, 4'h4));
        rows.push_back(mk("wrap",           0, 1, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0000, 16'h0000, 0, 4'h4));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    // 17 consecutive applied redirects starting from a count of 4
    task automatic test_back_to_back();
        row_t rows[$];
        row_t e;
        for (int k = 0; k < 17; k++) begin
            int src;
            int cnt;
            src = k % 4;
            cnt = (5 + k > 15) ? 15 : 5 + k;
            rows.push_back(mk("b2b", 0, 1, 4'(1 << src), 16'h1000 + 16'(4 * k), 0, 16'h0000,
                              1, 4'((1 << src) - 1), 16'h1000 + 16'(4 * k), 0, 4'(cnt)));
        end
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("hold_0700", 0, 0, 4'b0100, 16'h0700, 0, 16'h0000, 1, 4'b0011, 16'h1040, 1, 4'hF));
        rows.push_back(mk("hold_idle", 0, 0, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0011, 16'h1040, 1, 4'hF));
        rows.push_back(mk("rst_hold",  1, 1, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0011, 16'h0000, 0, 4'h0));
        rows.push_back(mk("post_rst1", 0, 1, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0000, 16'h0002, 0, 4'h0));
        rows.push_back(mk("post_rst2", 0, 1, 4'b0000, 16'h0000, 0, 16'h0000, 1, 4'b0000, 16'h0004, 0, 4'h0));
        foreach (rows[k]) begin
            apply(rows[k]); #1;
            if (rows[k].chk_sq) begin
                tests++;
                if (squash !== rows[k].sq) begin
                    failed++;
                    $display("FAIL %s squash: got %b expected %b", rows[k].name, squash, rows[k].sq);
                end
            end
            exp_q.push_back(rows[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({pc, pending_valid, redirect_count} !== {e.epc, e.epend, e.ecnt}) begin
                failed++;
                $display("FAIL %s state: got pc=%h pend=%b cnt=%h expected pc=%h pend=%b cnt=%h",
                         e.name, pc, pending_valid, redirect_count, e.epc, e.epend, e.ecnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_pred_vs_redirect();
        test_stall();
        test_tie_and_wrap();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
